irq_collector: RTL and testbench
================================

Name: irq_collector

Overview:
Interrupt collector that receives the single-cycle irq pulses produced by up to NUM_SRC counter instances. It latches each pulse into a per-source pending bit and records missed events as sticky overflow flags. A per-source enable mask gates which pending sources may be presented. It presents one interrupt at a time to a service agent through a valid/ack handshake, with fixed lowest-index-first priority.

Parameters:
NUM_SRC, 4, number of irq sources; legal range 2..16.
HOLDOFF_CYCLES, 2, idle cycles enforced after each ack before the next presentation; 0 is legal.
MASK_RESET, {NUM_SRC{1'b1}}, reset value of the mask register; bit=1 means enabled.
ID_W (localparam), $clog2(NUM_SRC), width of irq_id.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
irq_in  input  NUM_SRC  single-cycle event pulses, one bit per source, synchronous to clk
mask_we  input  1  write strobe for the mask register
mask_wdata  input  NUM_SRC  new mask value
mask  output  NUM_SRC  current mask register
irq_valid  output  1  an interrupt is being presented
irq_id  output  ID_W  index of the presented source; valid only while irq_valid=1
irq_ack  input  1  service agent accepts the presented interrupt
pending  output  NUM_SRC  pending bits, registered
overflow  output  NUM_SRC  sticky missed-event flags
ovf_clr  input  1  clears all overflow bits

Behaviour:
- Reset (async, rst_n=0): pending=0, overflow=0, mask=MASK_RESET, irq_valid=0, irq_id=0, state=IDLE, holdoff counter=0. Reset mid-handshake abandons the presented interrupt with no ack side effects.
- Pending capture: irq_in[i]=1 at edge n sets pending[i] at edge n. Capture happens regardless of mask.
- Overflow: irq_in[i]=1 while pending[i]=1 and pending[i] is not being cleared in the same cycle sets overflow[i]=1. The bit is sticky.
- ovf_clr=1 clears all overflow bits. If ovf_clr and a new overflow event coincide, the event wins and the bit stays 1.
- Ack clear: irq_ack in REQ clears pending[irq_id]. If irq_in[irq_id]=1 in the same cycle, the pulse wins: pending stays 1 and overflow is not set.
- Mask: mask_we=1 loads mask_wdata, effective the next cycle. Masking never clears pending bits.
- FSM states IDLE, REQ, HOLD:
  - IDLE: if (pending & mask)!=0, latch irq_id = lowest set index, set irq_valid=1, go to REQ. Otherwise stay in IDLE.
  - REQ: irq_valid=1, irq_id held stable until ack, even if mask or pending change. Ack is accepted when irq_valid & irq_ack: clear pending, irq_valid=0 on the next edge. Then go to HOLD with counter=HOLDOFF_CYCLES, or go straight to IDLE if HOLDOFF_CYCLES=0.
  - HOLD: counter decrements each cycle; at 1, go to IDLE. irq_valid=0 throughout.
- irq_ack outside REQ is ignored.
- Latency: pulse at edge n, pending visible after edge n, irq_valid=1 after edge n+1 (2-cycle pulse-to-valid from IDLE).
- Gap: ack at edge a, irq_valid=0 after a. With HOLDOFF_CYCLES=H, the next irq_valid rises after edge a+H+1.
- Simultaneous pulses on several sources are all captured in one cycle; they are served in index order.
- Priority is fixed, with no fairness: a continuously re-pulsing low index may starve higher indices. This is intended.

Test Plan:
1. Reset, then irq_in=4'b0100 for 1 cycle -> pending=4'b0100; 2 cycles later irq_valid=1, irq_id=2; ack -> pending=0, irq_valid=0, no re-assert.
2. irq_in=4'b1010 in one cycle -> served as id=1, then id=3; gap between irq_valid=0 and the next assertion = HOLDOFF_CYCLES+1 = 3 cycles.
3. Two pulses on source 0 with no ack between them -> overflow=4'b0001; ovf_clr -> overflow=0; pending[0] still 1.
4. mask=4'b1110, pulse source 0 -> pending[0]=1, irq_valid stays 0; write mask=4'b1111 -> irq_valid=1, id=0 two cycles after the write.
5. In REQ with id=1, assert irq_ack and irq_in[1] in the same cycle -> pending[1] stays 1, overflow[1]=0, id=1 re-presented after the holdoff.
6. Assert rst_n=0 while in REQ with pending=4'b0011 -> all outputs return to reset values immediately; after release, no irq_valid until a new pulse arrives.

Source files
------------

// File: rtl/irq_collector.sv
// Interrupt collector: latches single-cycle irq pulses into pending bits with
// sticky overflow and presents them one at a time, lowest index first, via valid/ack.
module irq_collector #(
   parameter int                NUM_SRC        = 4,
   parameter int                HOLDOFF_CYCLES = 2,
   parameter logic [NUM_SRC-1:0] MASK_RESET    = {NUM_SRC{1'b1}},
   localparam int               ID_W           = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wdata,
   output logic [NUM_SRC-1:0] mask,
   output logic               irq_valid,
   output logic [ID_W-1:0]    irq_id,
   input  logic               irq_ack,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] overflow,
   input  logic               ovf_clr,
   output logic [1:0]         dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam int CNT_W = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

   // Handshake: the presented id is accepted on any rising edge where irq_valid
   // and irq_ack are both 1; irq_id is frozen from assertion until acceptance.
   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_overflow;
   logic [NUM_SRC-1:0] r_mask;
   logic               r_valid;
   logic [ID_W-1:0]    r_id;

   logic [NUM_SRC-1:0] w_req;
   logic               w_any;
   logic [ID_W-1:0]    w_sel_id;
   logic               w_ack;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_new_ovf;

   always_comb begin
      w_req    = r_pending & r_mask;
      w_any    = |w_req;
      w_sel_id = '0;
      // Descending scan so the lowest set index is the last one written.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_req[i]) w_sel_id = ID_W'(i);
      end
   end

   always_comb begin
      w_ack     = (r_state == S_REQ) && irq_ack;
      w_clr     = w_ack ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << r_id) : '0;
      // A pulse landing on a bit that is being acked re-arms it, not an overflow.
      w_new_ovf = irq_in & r_pending & ~w_clr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending  <= '0;
         r_overflow <= '0;
         r_mask     <= MASK_RESET;
      end else begin
         r_pending  <= (r_pending & ~w_clr) | irq_in;
         r_overflow <= (ovf_clr ? '0 : r_overflow) | w_new_ovf;
         if (mask_we) r_mask <= mask_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_id    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_id    <= w_sel_id;
                  r_valid <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (irq_ack) begin
                  r_valid <= 1'b0;
                  if (HOLDOFF_CYCLES == 0) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt   <= CNT_W'(HOLDOFF_CYCLES);
                     r_state <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign mask      = r_mask;
   assign irq_valid = r_valid;
   assign irq_id    = r_id;
   assign pending   = r_pending;
   assign overflow  = r_overflow;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_irq_collector.sv
// Directed self-checking bench for irq_collector (NUM_SRC=4, HOLDOFF_CYCLES=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_irq_collector;

   logic       clk;
   logic       rst_n;
   logic [3:0] irq_in;
   logic       mask_we;
   logic [3:0] mask_wdata;
   logic [3:0] mask;
   logic       irq_valid;
   logic [1:0] irq_id;
   logic       irq_ack;
   logic [3:0] pending;
   logic [3:0] overflow;
   logic       ovf_clr;
   logic [1:0] dbg_state;

   int passed = 0;
   int total  = 0;

   irq_collector #(.NUM_SRC(4), .HOLDOFF_CYCLES(2), .MASK_RESET(4'b1111)) dut (
      .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask_we(mask_we),
      .mask_wdata(mask_wdata), .mask(mask), .irq_valid(irq_valid),
      .irq_id(irq_id), .irq_ack(irq_ack), .pending(pending),
      .overflow(overflow), .ovf_clr(ovf_clr), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic pulse(input logic [3:0] v);
      irq_in = v;
      @(negedge clk);
      irq_in = '0;
   endtask

   task automatic ack_once();
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Counts sampled cycles with irq_valid=0, starting at the current sample.
   task automatic gap_count(output int cnt);
      cnt = 0;
      while (!irq_valid && cnt < 20) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
      irq_ack = 1'b0; ovf_clr = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(1);
      total++; if ({pending, overflow, mask} !== 12'h00F) $display("FAIL reset_regs got=%h exp=00f", {pending, overflow, mask}); else passed++;
      total++; if ({irq_valid, irq_id} !== 3'b000) $display("FAIL reset_valid_id got=%b exp=000", {irq_valid, irq_id}); else passed++;
   endtask

   task automatic test_single();
      pulse(4'b0100);
      total++; if (pending !== 4'b0100 || irq_valid !== 1'b0) $display("FAIL single_capture pend=%b valid=%b exp pend=0100 valid=0", pending, irq_valid); else passed++;
      idle(1);
      total++; if (irq_valid !== 1'b1 || irq_id !== 2'd2) $display("FAIL single_present valid=%b id=%0d exp valid=1 id=2", irq_valid, irq_id); else passed++;
      ack_once();
      total++; if (pending !== 4'b0000 || irq_valid !== 1'b0) $display("FAIL single_ack pend=%b valid=%b exp pend=0000 valid=0", pending, irq_valid); else passed++;
      idle(6);
      total++; if (irq_valid !== 1'b0) $display("FAIL single_no_reassert valid=%b exp=0", irq_valid); else passed++;
   endtask

   task automatic test_back_to_back();
      int gap;
      pulse(4'b1010);
      total++; if (pending !== 4'b1010) $display("FAIL b2b_capture pend=%b exp=1010", pending); else passed++;
      idle(1);
      total++; if (irq_valid !== 1'b1 || irq_id !== 2'd1) $display("FAIL b2b_first valid=%b id=%0d exp valid=1 id=1", irq_valid, irq_id); else passed++;
      ack_once();
      gap_count(gap);
      total++; if (gap !== 3) $display("FAIL b2b_gap got=%0d exp=3", gap); else passed++;
      total++; if (irq_valid !== 1'b1 || irq_id !== 2'd3 || pending !== 4'b1000) $display("FAIL b2b_second valid=%b id=%0d pend=%b exp valid=1 id=3 pend=1000", irq_valid, irq_id, pending); else passed++;
      ack_once();
      total++; if (pending !== 4'b0000 || irq_valid !== 1'b0) $display("FAIL b2b_done pend=%b valid=%b exp 0000/0", pending, irq_valid); else passed++;
      idle(4);
   endtask

   task automatic test_overflow();
      pulse(4'b0001);
      pulse(4'b0001);
      total++; if (overflow !== 4'b0001 || pending !== 4'b0001) $display("FAIL ovf_set ovf=%b pend=%b exp 0001/0001", overflow, pending); else passed++;
      // New event coinciding with the clear keeps the bit set.
      irq_in = 4'b0001; ovf_clr = 1'b1;
      @(negedge clk);
      irq_in = '0; ovf_clr = 1'b0;
      total++; if (overflow !== 4'b0001) $display("FAIL ovf_clr_vs_event ovf=%b exp=0001", overflow); else passed++;
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      total++; if (overflow !== 4'b0000 || pending !== 4'b0001) $display("FAIL ovf_clr ovf=%b pend=%b exp 0000/0001", overflow, pending); else passed++;
      total++; if (irq_valid !== 1'b1 || irq_id !== 2'd0) $display("FAIL ovf_present valid=%b id=%0d exp valid=1 id=0", irq_valid, irq_id); else passed++;
      ack_once();
      total++; if (pending !== 4'b0000) $display("FAIL ovf_ack pend=%b exp=0000", pending); else passed++;
      idle(4);
   endtask

   task automatic test_mask();
      mask_we = 1'b1; mask_wdata = 4'b1110;
      @(negedge clk);
      mask_we = 1'b0;
      total++; if (mask !== 4'b1110) $display("FAIL mask_write got=%b exp=1110", mask); else passed++;
      pulse(4'b0001);
      idle(3);
      total++; if (pending !== 4'b0001 || irq_valid !== 1'b0) $display("FAIL mask_block pend=%b valid=%b exp 0001/0", pending, irq_valid); else passed++;
      // Ack while idle must not touch pending.
      ack_once();
      total++; if (pending !== 4'b0001 || irq_valid !== 1'b0) $display("FAIL ack_ignored pend=%b valid=%b exp 0001/0", pending, irq_valid); else passed++;
      mask_we = 1'b1; mask_wdata = 4'b1111;
      @(negedge clk);
      mask_we = 1'b0;
      total++; if (mask !== 4'b1111 || irq_valid !== 1'b0) $display("FAIL mask_unblock_t1 mask=%b valid=%b exp 1111/0", mask, irq_valid); else passed++;
      idle(1);
      total++; if (irq_valid !== 1'b1 || irq_id !== 2'd0) $display("FAIL mask_unblock_t2 valid=%b id=%0d exp valid=1 id=0", irq_valid, irq_id); else passed++;
      ack_once();
      idle(4);
   endtask

   task automatic test_ack_collision();
      int gap;
      pulse(4'b0010);
      idle(1);
      total++; if (irq_valid !== 1'b1 || irq_id !== 2'd1) $display("FAIL coll_present valid=%b id=%0d exp valid=1 id=1", irq_valid, irq_id); else passed++;
      irq_ack = 1'b1; irq_in = 4'b0010;
      @(negedge clk);
      irq_ack = 1'b0; irq_in = '0;
      total++; if (pending !== 4'b0010 || overflow !== 4'b0000 || irq_valid !== 1'b0) $display("FAIL coll_pulse_wins pend=%b ovf=%b valid=%b exp 0010/0000/0", pending, overflow, irq_valid); else passed++;
      gap_count(gap);
      total++; if (gap !== 3 || irq_id !== 2'd1) $display("FAIL coll_represent gap=%0d id=%0d exp gap=3 id=1", gap, irq_id); else passed++;
      ack_once();
      idle(4);
   endtask

   task automatic test_reset_mid_req();
      pulse(4'b0011);
      idle(1);
      total++; if (irq_valid !== 1'b1 || irq_id !== 2'd0 || pending !== 4'b0011) $display("FAIL rst_pre valid=%b id=%0d pend=%b exp 1/0/0011", irq_valid, irq_id, pending); else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++; if ({irq_valid, irq_id, pending, overflow, mask} !== 15'h000F) $display("FAIL rst_async got=%h exp=000f", {irq_valid, irq_id, pending, overflow, mask}); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      idle(5);
      total++; if (irq_valid !== 1'b0 || pending !== 4'b0000) $display("FAIL rst_quiet valid=%b pend=%b exp 0/0000", irq_valid, pending); else passed++;
      pulse(4'b1000);
      idle(1);
      total++; if (irq_valid !== 1'b1 || irq_id !== 2'd3) $display("FAIL rst_new_pulse valid=%b id=%0d exp valid=1 id=3", irq_valid, irq_id); else passed++;
      ack_once();
      idle(4);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_mask();
      test_ack_collision();
      test_reset_mid_req();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
